// File: rtl/c3lib_strap_capture.sv
// rtl/c3lib_strap_capture.sv - strap synchronizer, glitch filter and lock register
// Every pass through FILTER spends one edge loading the reference value, so lock latency is fixed.
module c3lib_strap_capture #(
  parameter int WIDTH      = 8,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] strap_in,
  input  logic             capture_req,
  output logic [WIDTH-1:0] strap_out,
  output logic             strap_vld,
  output logic             strap_chg
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT - 1);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_FILTER = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sync1_q, sync1_d;
  logic [WIDTH-1:0]   sync2_q, sync2_d;
  logic [WIDTH-1:0]   last_q, last_d;
  logic [WIDTH-1:0]   strap_out_q, strap_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               fill_q, fill_d;
  logic               fresh_q, fresh_d;
  logic               strap_vld_q, strap_vld_d;
  logic               strap_chg_q, strap_chg_d;
  logic               locked_once_q, locked_once_d;

  always_comb begin
    sync1_d       = strap_in;
    sync2_d       = sync1_q;
    state_d       = state_q;
    last_d        = last_q;
    strap_out_d   = strap_out_q;
    cnt_d         = cnt_q;
    fill_d        = fill_q;
    fresh_d       = fresh_q;
    strap_vld_d   = strap_vld_q;
    strap_chg_d   = 1'b0;
    locked_once_d = locked_once_q;

    case (state_q)
      ST_SYNC: begin
        if (fill_q) begin
          state_d = ST_FILTER;
          fresh_d = 1'b1;
          cnt_d   = '0;
        end else begin
          fill_d = 1'b1;
        end
      end

      ST_FILTER: begin
        // A restart request outranks a lock landing on the same edge.
        if (capture_req) begin
          fresh_d = 1'b1;
          cnt_d   = '0;
        end else if (fresh_q) begin
          fresh_d = 1'b0;
          last_d  = sync2_q;
          cnt_d   = '0;
        end else if (sync2_q == last_q) begin
          last_d = sync2_q;
          if (cnt_q == CNT_MAX) begin
            state_d       = ST_LOCKED;
            strap_out_d   = sync2_q;
            strap_vld_d   = 1'b1;
            strap_chg_d   = locked_once_q && (sync2_q != strap_out_q);
            locked_once_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else begin
          last_d = sync2_q;
          cnt_d  = '0;
        end
      end

      ST_LOCKED: begin
        if (capture_req) begin
          state_d     = ST_FILTER;
          fresh_d     = 1'b1;
          cnt_d       = '0;
          strap_vld_d = 1'b0;
        end
      end

      default: begin
        state_d = ST_SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_SYNC;
      sync1_q       <= '0;
      sync2_q       <= '0;
      last_q        <= '0;
      strap_out_q   <= '0;
      cnt_q         <= '0;
      fill_q        <= 1'b0;
      fresh_q       <= 1'b0;
      strap_vld_q   <= 1'b0;
      strap_chg_q   <= 1'b0;
      locked_once_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      last_q        <= last_d;
      strap_out_q   <= strap_out_d;
      cnt_q         <= cnt_d;
      fill_q        <= fill_d;
      fresh_q       <= fresh_d;
      strap_vld_q   <= strap_vld_d;
      strap_chg_q   <= strap_chg_d;
      locked_once_q <= locked_once_d;
    end
  end

  assign strap_out = strap_out_q;
  assign strap_vld = strap_vld_q;
  assign strap_chg = strap_chg_q;

endmodule

// File: tb/tb_c3lib_strap_capture.sv
// tb/tb_c3lib_strap_capture.sv - randomized and directed bench for c3lib_strap_capture
// The model locks when a window of STABLE_CNT+1 equal synchronized samples follows the last restart.
module tb_c3lib_strap_capture;

  localparam int W  = 8;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] strap_in = '0;
  logic         capture_req = 1'b0;
  logic [W-1:0] strap_out;
  logic         strap_vld;
  logic         strap_chg;

  int checks = 0;
  int errors = 0;

  c3lib_strap_capture #(.WIDTH(W), .STABLE_CNT(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .strap_in    (strap_in),
    .capture_req (capture_req),
    .strap_out   (strap_out),
    .strap_vld   (strap_vld),
    .strap_chg   (strap_chg)
  );

  always #5 clk = ~clk;

  // Reference model state
  int           cyc = 0;
  int           mmode = 0;
  int           nsync = 0;
  int           rstart = 0;
  bit           ever = 0;
  logic [W-1:0] p1 = '0, p2 = '0;
  logic [W-1:0] smp [0:8191];
  logic [W-1:0] exp_out = '0;
  logic         exp_vld = 1'b0;
  logic         exp_chg = 1'b0;

  function automatic bit window_equal(int e);
    for (int i = e - SC; i < e; i++)
      if (smp[i] !== smp[e]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input logic [W-1:0] s, input logic req, input logic r);
    if (r) begin
      mmode = 0; nsync = 0; ever = 0;
      p1 = '0; p2 = '0;
      exp_out = '0; exp_vld = 1'b0; exp_chg = 1'b0;
    end else begin
      smp[cyc] = p2;
      exp_chg = 1'b0;
      case (mmode)
        0: begin
          nsync++;
          if (nsync == 2) begin mmode = 1; rstart = cyc; end
        end
        1: begin
          if (req) rstart = cyc;
          else if ((cyc - SC >= rstart + 1) && window_equal(cyc)) begin
            exp_chg = ever && (smp[cyc] != exp_out);
            exp_out = smp[cyc];
            exp_vld = 1'b1;
            ever    = 1'b1;
            mmode   = 2;
          end
        end
        default: begin
          if (req) begin mmode = 1; rstart = cyc; exp_vld = 1'b0; end
        end
      endcase
      p2 = p1;
      p1 = s;
    end
    cyc++;
  endtask

  task automatic tick(input logic [W-1:0] s, input logic req, input logic r);
    strap_in = s; capture_req = req; rst = r;
    @(posedge clk);
    model_edge(s, req, r);
    @(negedge clk);
  endtask

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      tick($urandom, 1'($urandom), 1'b1);
      checks++;
      if ({strap_out, strap_vld, strap_chg} !== {8'h00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset: got out=%h vld=%b chg=%b want 00/0/0", strap_out, strap_vld, strap_chg);
      end
    end
  endtask

  task automatic test_first_lock;
    tick(8'hA5, 1'b0, 1'b1);
    for (int e = 1; e <= 8; e++) begin
      tick(8'hA5, 1'b0, 1'b0);
      checks++;
      if ({strap_out, strap_vld, strap_chg} !== {exp_out, exp_vld, exp_chg}) begin
        errors++;
        $display("FAIL first_lock edge %0d: got %h/%b/%b want %h/%b/%b", e, strap_out, strap_vld, strap_chg, exp_out, exp_vld, exp_chg);
      end
      checks++;
      if (strap_vld !== (e >= SC + 3) || strap_chg !== 1'b0) begin
        errors++;
        $display("FAIL first_lock_latency edge %0d: got vld=%b chg=%b want vld=%b chg=0", e, strap_vld, strap_chg, (e >= SC + 3));
      end
    end
    checks++;
    if (strap_out !== 8'hA5) begin
      errors++;
      $display("FAIL first_lock_value: got %h want a5", strap_out);
    end
  endtask

  task automatic test_glitch;
    tick(8'h3C, 1'b0, 1'b1);
    for (int e = 1; e <= 16; e++) begin
      tick((e == 5) ? 8'h3D : 8'h3C, 1'b0, 1'b0);
      checks++;
      if ({strap_out, strap_vld, strap_chg} !== {exp_out, exp_vld, exp_chg}) begin
        errors++;
        $display("FAIL glitch edge %0d: got %h/%b/%b want %h/%b/%b", e, strap_out, strap_vld, strap_chg, exp_out, exp_vld, exp_chg);
      end
    end
    // Glitch sampled at edge 5 reaches sync2 for edge 7; clean again at 8, lock 4 edges later.
    checks++;
    if (strap_out !== 8'h3C || strap_vld !== 1'b1) begin
      errors++;
      $display("FAIL glitch_final: got %h/%b want 3c/1", strap_out, strap_vld);
    end
  endtask

  task automatic test_hold_and_recapture;
    tick(8'h11, 1'b0, 1'b1);
    for (int e = 1; e <= 7; e++) tick(8'h11, 1'b0, 1'b0);
    for (int e = 0; e < 10; e++) begin
      tick(8'h22, 1'b0, 1'b0);
      checks++;
      if (strap_out !== 8'h11 || strap_vld !== 1'b1 || strap_chg !== 1'b0) begin
        errors++;
        $display("FAIL hold: got %h/%b/%b want 11/1/0", strap_out, strap_vld, strap_chg);
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      tick(8'h22, 1'b1, 1'b0);
      checks++;
      if (strap_vld !== 1'b0 || strap_out !== (pass == 0 ? 8'h11 : 8'h22)) begin
        errors++;
        $display("FAIL recap_drop pass %0d: got %h/%b", pass, strap_out, strap_vld);
      end
      for (int e = 1; e <= SC + 2; e++) begin
        tick(8'h22, 1'b0, 1'b0);
        checks++;
        if ({strap_out, strap_vld, strap_chg} !== {exp_out, exp_vld, exp_chg}) begin
          errors++;
          $display("FAIL recap_model pass %0d edge %0d: got %h/%b/%b want %h/%b/%b", pass, e, strap_out, strap_vld, strap_chg, exp_out, exp_vld, exp_chg);
        end
        checks++;
        if (strap_vld !== (e >= SC + 1) || strap_chg !== (pass == 0 && e == SC + 1)) begin
          errors++;
          $display("FAIL recap_latency pass %0d edge %0d: got vld=%b chg=%b", pass, e, strap_vld, strap_chg);
        end
      end
    end
  endtask

  task automatic test_req_storm;
    tick(8'h5A, 1'b0, 1'b1);
    for (int e = 1; e <= 30; e++) begin
      tick(8'h5A, (e % 3 == 0), 1'b0);
      checks++;
      if (strap_vld !== 1'b0 || strap_vld !== exp_vld) begin
        errors++;
        $display("FAIL req_storm edge %0d: got vld=%b want 0", e, strap_vld);
      end
    end
    for (int e = 1; e <= 6; e++) tick(8'h5A, 1'b0, 1'b0);
    checks++;
    if (strap_vld !== 1'b1 || strap_out !== 8'h5A) begin
      errors++;
      $display("FAIL req_storm_release: got %h/%b want 5a/1", strap_out, strap_vld);
    end
  endtask

  task automatic test_mid_reset;
    tick(8'hC3, 1'b0, 1'b1);
    for (int e = 1; e <= 9; e++) tick(8'hC3, 1'b0, 1'b0);
    tick(8'hC3, 1'b0, 1'b1);
    checks++;
    if (strap_out !== 8'h00 || strap_vld !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got %h/%b want 00/0", strap_out, strap_vld);
    end
    for (int e = 1; e <= 7; e++) begin
      tick(8'hC3, 1'b0, 1'b0);
      checks++;
      if (strap_vld !== (e == 7) || strap_chg !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_relock edge %0d: got vld=%b chg=%b", e, strap_vld, strap_chg);
      end
    end
  endtask

  task automatic test_random;
    logic [W-1:0] s;
    s = $urandom;
    tick(s, 1'b0, 1'b1);
    for (int e = 0; e < 400; e++) begin
      if ($urandom_range(0, 7) == 0) s = ($urandom_range(0, 1) == 0) ? (s ^ 8'h01) : W'($urandom);
      tick(s, ($urandom_range(0, 13) == 0), ($urandom_range(0, 149) == 0));
      checks++;
      if ({strap_out, strap_vld, strap_chg} !== {exp_out, exp_vld, exp_chg}) begin
        errors++;
        $display("FAIL random cyc %0d: got %h/%b/%b want %h/%b/%b", cyc, strap_out, strap_vld, strap_chg, exp_out, exp_vld, exp_chg);
      end
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset;
    test_first_lock;
    test_glitch;
    test_hold_and_recapture;
    test_req_storm;
    test_mid_reset;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
